// File: rtl/max_pool_bram_reader.sv
// max_pool_bram_reader
// Read-side engine for the max-pool output BRAM (port B, read-only use).
// Streams len consecutive 32-bit words from base_addr over a valid/ready
// interface with m_last on the final word. A small credit-controlled FIFO
// absorbs the fixed BRAM read latency so backpressure never drops or
// duplicates a word.
// Optional feature: define MP_READER_CHKSUM_EN to add a 32-bit running sum
// of every streamed word on output port chksum.
module max_pool_bram_reader #(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  output logic [3:0]       bram_we,
  output logic [31:0]      bram_din,
  input  logic [31:0]      bram_dout,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
`ifdef MP_READER_CHKSUM_EN
  ,
  output logic [31:0]      chksum
`endif
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        addr_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   issue_cnt_r;
  logic [LEN_W-1:0]   pop_cnt_r;
  logic [RD_LAT-1:0]  en_pipe_r;
  logic [31:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   occ_r;
  logic [CNT_W-1:0]   inflight_s;
  logic               credit_ok_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic               head_last_s;
  logic               accept_s;

  // Advance a FIFO pointer, wrapping at the (possibly non power-of-two) depth.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Count reads issued to the BRAM whose data has not yet been captured.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + CNT_W'(en_pipe_r[i]);
    end
  end

  // Credit check, issue/push/pop strobes and last-word detection.
  always_comb begin
    credit_ok_s = ({1'b0, occ_r} + {1'b0, inflight_s}) < (CNT_W + 1)'(FIFO_DEPTH);
    issue_s     = (state_r == RUN) && credit_ok_s;
    push_s      = en_pipe_r[RD_LAT-1];
    pop_s       = (occ_r != '0) && m_ready;
    head_last_s = (occ_r != '0) && (pop_cnt_r == (len_r - LEN_W'(1)));
    accept_s    = (state_r == IDLE) && start;
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && ((issue_cnt_r + LEN_W'(1)) == len_r)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && head_last_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transfer bookkeeping: latched length, running address, issue/pop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= 32'h0;
      len_r       <= '0;
      issue_cnt_r <= '0;
      pop_cnt_r   <= '0;
    end else if (accept_s) begin
      addr_r      <= {base_addr[31:2], 2'b00};
      len_r       <= len;
      issue_cnt_r <= '0;
      pop_cnt_r   <= '0;
    end else begin
      if (issue_s) begin
        addr_r      <= addr_r + 32'd4;
        issue_cnt_r <= issue_cnt_r + LEN_W'(1);
      end
      if (pop_s) begin
        pop_cnt_r <= pop_cnt_r + LEN_W'(1);
      end
    end
  end

  // Delay line marking which cycles carry valid BRAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe_r <= '0;
    end else begin
      en_pipe_r[0] <= issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe_r[i] <= en_pipe_r[i-1];
      end
    end
  end

  // Output FIFO: unconditional push of returning data, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 32'h0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bram_dout;
        wr_ptr_r             <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_W'(1);
        2'b01:   occ_r <= occ_r - CNT_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

`ifdef MP_READER_CHKSUM_EN
  logic [31:0] chksum_r;

  // Running sum of streamed words, cleared when a transfer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum_r <= 32'h0;
    end else if (accept_s) begin
      chksum_r <= 32'h0;
    end else if (pop_s) begin
      chksum_r <= chksum_r + m_data;
    end else begin
      chksum_r <= chksum_r;
    end
  end

  assign chksum = chksum_r;
`endif

  // Port decode from registered state; all zero while in reset.
  always_comb begin
    busy      = (state_r == RUN) || (state_r == DRAIN);
    done      = (state_r == DONE);
    bram_en   = issue_s;
    bram_addr = issue_s ? addr_r : 32'h0;
    bram_we   = 4'h0;
    bram_din  = 32'h0;
    m_valid   = (occ_r != '0);
    m_data    = m_valid ? fifo_mem_r[rd_ptr_r] : 32'h0;
    m_last    = head_last_s;
  end

endmodule

// File: tb/tb_max_pool_bram_reader.sv
// Directed testbench for max_pool_bram_reader (RD_LAT=1, FIFO depth 3).
module tb_max_pool_bram_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [15:0] len = 16'h0;
  logic        busy, done, bram_en, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [31:0] bram_addr, bram_din, m_data;
  logic [31:0] bram_dout = 32'h0;
  logic [3:0]  bram_we;
`ifdef MP_READER_CHKSUM_EN
  logic [31:0] chksum;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // statistics gathered by run_xfer
  logic [31:0] cur_base;
  logic [31:0] exp_addr;
  logic [31:0] addrs [4];
  logic [31:0] held_data;
  logic [31:0] chk_at_done;
  bit          held;
  int n_issue, n_words, n_done, n_busy, addr_err, order_err, last_err, stable_err;
  int first_en, first_valid, done_cycle, last_cyc, max_out, issue_at_stall;

  max_pool_bram_reader #(.RD_LAT(1), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef MP_READER_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model, 1-cycle latency: word k of the current block holds 0xA0+k
  always @(posedge clk) begin
    if (bram_en) bram_dout <= 32'hA0 + ((bram_addr - cur_base) >> 2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer and gathers statistics (no pass/fail decisions here).
  // mode 0: ready high, 1: ready toggles, 2: ready low for cycles 1..stall.
  task automatic run_xfer(input logic [31:0] b, input logic [15:0] l,
                          input int mode, input int stall, input int spur_cyc);
    int cyc;
    n_issue = 0; n_words = 0; n_done = 0; n_busy = 0; addr_err = 0;
    order_err = 0; last_err = 0; stable_err = 0; first_en = -1;
    first_valid = -1; done_cycle = -1; last_cyc = -1; max_out = 0;
    issue_at_stall = -1; held = 1'b0; chk_at_done = 32'h0;
    for (int i = 0; i < 4; i++) addrs[i] = 32'h0;
    cur_base = {b[31:2], 2'b00};
    exp_addr = cur_base;
    base_addr = b; len = l; start = 1'b1; m_ready = (mode == 0);
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !(n_done > 0 && cyc > done_cycle + 2)) begin
      if (cyc == spur_cyc) begin start = 1'b1; len = l + 16'd5; end
      else start = 1'b0;
      case (mode)
        1:       m_ready = ((cyc % 2) == 1);
        2:       m_ready = (cyc > stall);
        default: m_ready = 1'b1;
      endcase
      if (bram_en) begin
        if (first_en < 0) first_en = cyc;
        if (n_issue < 4) addrs[n_issue] = bram_addr;
        if (bram_addr !== exp_addr) addr_err++;
        exp_addr = exp_addr + 32'd4;
        n_issue++;
      end
      if (busy) n_busy++;
      if (n_issue - n_words > max_out) max_out = n_issue - n_words;
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (held && m_data !== held_data) stable_err++;
      end
      if (m_valid && m_ready) begin
        if (m_data !== 32'hA0 + n_words) order_err++;
        if (m_last !== (n_words == int'(l) - 1)) last_err++;
        if (m_last) last_cyc = cyc;
        n_words++;
        held = 1'b0;
      end else if (m_valid) begin
        held = 1'b1; held_data = m_data;
      end else begin
        held = 1'b0;
      end
      if (done) begin
        n_done++; done_cycle = cyc;
`ifdef MP_READER_CHKSUM_EN
        chk_at_done = chksum;
`endif
      end
      if (cyc == stall) issue_at_stall = n_issue;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({busy, done, bram_en, m_valid, m_last} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, bram_en, m_valid, m_last});
    end
    tests_run++;
    if ({bram_addr, m_data, bram_din, bram_we} !== 100'h0) begin
      tests_failed++; $display("FAIL reset_data addr=%h data=%h din=%h we=%h want all 0", bram_addr, m_data, bram_din, bram_we);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_xfer(32'h100, 16'd4, 0, 0, -1);
    tests_run++;
    if (first_en !== 1) begin tests_failed++; $display("FAIL basic_first_en got=%0d want=1", first_en); end
    tests_run++;
    if (addrs[0] !== 32'h100 || addrs[1] !== 32'h104 || addrs[2] !== 32'h108 || addrs[3] !== 32'h10C || n_issue !== 4) begin
      tests_failed++; $display("FAIL basic_addrs got=%h %h %h %h n=%0d want=100 104 108 10c n=4", addrs[0], addrs[1], addrs[2], addrs[3], n_issue);
    end
    tests_run++;
    if (first_valid !== 3) begin tests_failed++; $display("FAIL basic_first_valid got=%0d want=3", first_valid); end
    tests_run++;
    if (n_words !== 4 || order_err !== 0) begin tests_failed++; $display("FAIL basic_data words=%0d order_err=%0d want 4/0", n_words, order_err); end
    tests_run++;
    if (last_err !== 0 || last_cyc !== 6) begin tests_failed++; $display("FAIL basic_last err=%0d cyc=%0d want 0/6", last_err, last_cyc); end
    tests_run++;
    if (done_cycle !== 7 || n_done !== 1) begin tests_failed++; $display("FAIL basic_done cyc=%0d n=%0d want 7/1", done_cycle, n_done); end
    tests_run++;
    if (n_busy !== 6) begin tests_failed++; $display("FAIL basic_busy cycles=%0d want=6", n_busy); end
`ifdef MP_READER_CHKSUM_EN
    tests_run++;
    if (chk_at_done !== 32'h286) begin tests_failed++; $display("FAIL basic_chksum got=%h want=00000286", chk_at_done); end
`endif
  endtask

  task automatic test_toggle_ready();
    run_xfer(32'h100, 16'd4, 1, 0, -1);
    tests_run++;
    if (n_words !== 4 || order_err !== 0 || last_err !== 0) begin
      tests_failed++; $display("FAIL toggle_data words=%0d order_err=%0d last_err=%0d want 4/0/0", n_words, order_err, last_err);
    end
    tests_run++;
    if (stable_err !== 0) begin tests_failed++; $display("FAIL toggle_stable changes=%0d want=0", stable_err); end
    tests_run++;
    if (max_out > 3 || n_done !== 1) begin tests_failed++; $display("FAIL toggle_occ max_out=%0d done=%0d want <=3/1", max_out, n_done); end
  endtask

  task automatic test_backpressure();
    run_xfer(32'h400, 16'd16, 2, 20, -1);
    tests_run++;
    if (issue_at_stall !== 3) begin tests_failed++; $display("FAIL bp_credit issued=%0d want=3", issue_at_stall); end
    tests_run++;
    if (n_words !== 16 || order_err !== 0 || last_err !== 0 || stable_err !== 0) begin
      tests_failed++; $display("FAIL bp_data words=%0d order=%0d last=%0d stable=%0d want 16/0/0/0", n_words, order_err, last_err, stable_err);
    end
    tests_run++;
    if (n_done !== 1 || max_out > 3 || addr_err !== 0) begin
      tests_failed++; $display("FAIL bp_done done=%0d max_out=%0d addr_err=%0d want 1/<=3/0", n_done, max_out, addr_err);
    end
  endtask

  task automatic test_len_zero();
    run_xfer(32'h100, 16'd0, 0, 0, -1);
    tests_run++;
    if (n_issue !== 0 || first_valid !== -1 || n_busy !== 0) begin
      tests_failed++; $display("FAIL len0_quiet issues=%0d valid_at=%0d busy=%0d want 0/-1/0", n_issue, first_valid, n_busy);
    end
    tests_run++;
    if (done_cycle !== 1 || n_done !== 1) begin tests_failed++; $display("FAIL len0_done cyc=%0d n=%0d want 1/1", done_cycle, n_done); end
  endtask

  task automatic test_start_while_busy();
    run_xfer(32'h100, 16'd4, 0, 0, 2);
    tests_run++;
    if (n_words !== 4 || n_issue !== 4 || n_done !== 1 || order_err !== 0) begin
      tests_failed++; $display("FAIL busy_start words=%0d issues=%0d done=%0d order=%0d want 4/4/1/0", n_words, n_issue, n_done, order_err);
    end
  endtask

  task automatic test_addr_wrap();
    run_xfer(32'hFFFF_FFF8, 16'd3, 0, 0, -1);
    tests_run++;
    if (addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0 || n_issue !== 3) begin
      tests_failed++; $display("FAIL wrap_addrs got=%h %h %h n=%0d want fffffff8 fffffffc 00000000 n=3", addrs[0], addrs[1], addrs[2], n_issue);
    end
    tests_run++;
    if (n_words !== 3 || order_err !== 0 || n_done !== 1) begin
      tests_failed++; $display("FAIL wrap_data words=%0d order=%0d done=%0d want 3/0/1", n_words, order_err, n_done);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    cur_base = 32'h200;
    base_addr = 32'h200; len = 16'd8; start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bram_en, m_valid, m_last} !== 5'b0 || bram_addr !== 32'h0 || m_data !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_async ctrl=%b addr=%h data=%h want 0", {busy, done, bram_en, m_valid, m_last}, bram_addr, m_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || m_valid) dones++;
    end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL rstmid_nodone events=%0d want=0", dones); end
    run_xfer(32'h100, 16'd4, 0, 0, -1);
    tests_run++;
    if (n_words !== 4 || order_err !== 0 || n_done !== 1 || done_cycle !== 7) begin
      tests_failed++; $display("FAIL rstmid_restart words=%0d order=%0d done=%0d at %0d want 4/0/1/7", n_words, order_err, n_done, done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_ready();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_addr_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/max_pool_bram_reader.md
Name: max_pool_bram_reader

Overview:
- Read-side engine for the max-pool output BRAM. Drives BRAM port B (read-only use) and streams a contiguous block of 32-bit feature-map words to the next layer, over a valid/ready stream with last-word marking.
- Port A remains owned by the max-pool writer. This block sits between the BRAM wrapper's port B and the downstream dense/conv stage.
- Absorbs the fixed BRAM read latency with a small credit-controlled FIFO, so downstream backpressure never drops or duplicates a word.

Parameters:
- RD_LAT, 1, BRAM read latency in cycles, from bram_en/bram_addr to valid bram_dout; legal range 1..3.
- LEN_W, 16, width of the word-count input.
- FIFO_DEPTH, RD_LAT+2, local parameter, not overridable; depth of the output FIFO.

Ports:
- clk  in  1  single clock; also drives BRAM port B clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy.
- base_addr  in  32  byte address of the first word; bits[1:0] ignored, treated as 0.
- len  in  LEN_W  number of 32-bit words to read.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- bram_addr  out  32  port B byte address.
- bram_en  out  1  port B enable; high only on cycles that issue a read.
- bram_we  out  4  port B byte write enable; constant 4'h0.
- bram_din  out  32  port B write data; constant 0.
- bram_dout  in  32  port B read data.
- m_data  out  32  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from downstream.
- m_last  out  1  marks the final word of the transfer.

Behaviour:
- Reset (async assert, sync release) clears every output to 0. Also clears FIFO, counters, in-flight tracking and FSM (state IDLE). The bram_we and bram_din outputs are always 0.
- The start, base_addr and len inputs are sampled only in IDLE.
- FSM states:
  - IDLE: on start with len!=0, latch base and len, then go to RUN. On start with len==0, go to DONE; no reads issued, busy stays 0.
  - RUN: issue reads. Move to DRAIN when all len reads are issued.
  - DRAIN: wait until the last word handshakes (m_valid & m_ready & m_last), then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- busy is 1 in RUN and DRAIN, and 0 in IDLE and DONE.
- Read issue rules:
  - In RUN, a read issues in a cycle only when FIFO occupancy + in-flight reads < FIFO_DEPTH. Occupancy is counted before this cycle's pop.
  - On issue: bram_en=1 and bram_addr = base + 4*i, where i counts from 0 to len-1.
  - Address arithmetic is modulo 2^32, so it wraps from 0xFFFFFFFC to 0x00000000.
- Capture: data returned RD_LAT cycles after each issue is pushed into the FIFO unconditionally. The credit rule guarantees the FIFO never overflows.
- Stream output:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - A pop occurs when m_valid & m_ready.
  - Once asserted, m_valid and m_data hold stable until the handshake.
- m_last is 1 exactly when the head is word len-1. This is tracked by a pop counter.
- Latency with RD_LAT=1:
  - start at cycle 0, first bram_en at cycle 1, first m_valid at cycle 3.
  - With m_ready held high, throughput is 1 word/cycle, with no bubbles after the first word.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged.
- A start pulse during busy or DONE is ignored; there is no queueing.
- Reset mid-transfer aborts immediately: no done pulse, and in-flight data is discarded.
- The maximum transfer is len = 2^LEN_W - 1 words.

Optional Feature:
- Macro: MP_READER_CHKSUM_EN.
- Defined:
  - Adds output port chksum (32 bits).
  - chksum clears to 0 when a transfer starts.
  - It adds m_data (modulo 2^32) on every stream handshake.
  - Its value is final and stable in the DONE cycle and holds until the next start.
- Undefined: the chksum port and its logic are absent. All other behaviour is identical.

Test Plan:
- RD_LAT=1, base=0x100, len=4, BRAM word k = 0xA0+k, m_ready=1 -> bram_addr 0x100, 0x104, 0x108, 0x10C on cycles 1-4. Then m_data 0xA0..0xA3 on cycles 3-6, m_last only on 0xA3, done pulse on cycle 7.
- Same transfer, m_ready toggling 1/0 every cycle -> all 4 words delivered in order with no loss or duplication. FIFO occupancy never exceeds FIFO_DEPTH; m_data stays stable while m_ready=0.
- m_ready=0 for 20 cycles after start with len=16 -> bram_en stops after FIFO_DEPTH issues. After m_ready rises, 16 words stream in order and done pulses once.
- len=0 start -> no bram_en, no m_valid, busy stays 0, done pulses on cycle 1. A start issued while busy is ignored (word count unchanged).
- base=0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Separately, rst_n low mid-transfer -> all outputs 0 asynchronously, no done pulse, next start runs cleanly. With MP_READER_CHKSUM_EN and the first scenario -> chksum = 0x286 at done.
